// File: rtl/mem_port_arbiter.sv
// N-way arbiter multiplexing memory masters onto one registered memory port,
// with fixed-priority or round-robin selection and an optional BUSY watchdog.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 0,
  parameter int IDW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*2-1:0]      req_datasize,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*DATA_W-1:0] req_writedata,
  output logic [NUM_PORTS-1:0]        req_done,
  output logic [NUM_PORTS-1:0]        req_error,
  output logic [DATA_W-1:0]           rsp_readdata,
  output logic                        grant_valid,
  output logic [IDW-1:0]              grant_id,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [1:0]                  mem_datasize,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  input  logic [DATA_W-1:0]           mem_readdata,
  input  logic                        mem_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [CW-1:0]   wd_cnt_reg;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [1:0]        size_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_any;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
      assign size_arr[gi]  = req_datasize[gi*2 +: 2];
      assign wdata_arr[gi] = req_writedata[gi*DATA_W +: DATA_W];
      assign req_any[gi]   = req_read[gi] | req_write[gi];
    end
  endgenerate

  // Search starts at the pointer in round-robin mode, at port 0 otherwise.
  logic [IDW-1:0] winner;
  logic           found;
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (RR_MODE != 0) ? ((int'(rr_ptr_reg) + k) % NUM_PORTS) : k;
      if (!found && req_any[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  logic expire;
  logic finish;
  assign expire = (TIMEOUT != 0) && (state_reg == BUSY) && !mem_done && (wd_cnt_reg == WD_LAST);
  assign finish = (state_reg == BUSY) && (mem_done || expire);

  always_comb begin
    req_done  = '0;
    req_error = '0;
    if (finish) req_done[grant_id] = 1'b1;
    if (expire) req_error[grant_id] = 1'b1;
  end

  assign rsp_readdata = mem_readdata;

  logic [IDW-1:0] ptr_next;
  assign ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      wd_cnt_reg    <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      mem_address   <= '0;
      mem_datasize  <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            mem_address   <= addr_arr[winner];
            mem_datasize  <= size_arr[winner];
            mem_writedata <= wdata_arr[winner];
            // A simultaneous read and write request is treated as a write.
            mem_write     <= req_write[winner];
            mem_read      <= req_read[winner] & ~req_write[winner];
            grant_valid   <= 1'b1;
            grant_id      <= winner;
            wd_cnt_reg    <= '0;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            grant_valid <= 1'b0;
            wd_cnt_reg  <= '0;
            state_reg   <= IDLE;
            if (RR_MODE != 0) rr_ptr_reg <= ptr_next;
          end else if (TIMEOUT != 0) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
